// File: rtl/uart_report_sequencer.sv
// rtl/uart_report_sequencer.sv - shares the UART TX byte channel between BCD report frames and echo bytes
// Optional build macro: MINI_CALC_LEADING_ZERO_BLANK_EN (leading zero digits sent as spaces).
module uart_report_sequencer #(
  parameter bit         ADD_CRLF       = 1'b1,
  parameter logic [7:0] BAD_DIGIT_CHAR = 8'h3F
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReportReq,
  input  logic [3:0] Digit3,
  input  logic [3:0] Digit2,
  input  logic [3:0] Digit1,
  input  logic [3:0] Digit0,
  input  logic       EchoValid,
  input  logic [7:0] EchoData,
  output logic       EchoAck,
  output logic [7:0] TxData,
  output logic       TxValid,
  input  logic       TxAck,
  output logic       Busy,
  output logic       Overrun
);

  typedef enum logic [2:0] {
    IDLE, SEND_ECHO, SEND_D3, SEND_D2, SEND_D1, SEND_D0, SEND_CR, SEND_LF
  } state_t;

  state_t      state, stateNext;
  logic        pending;
  logic [15:0] snapshot;
  logic [15:0] frame;
  logic        lastGrantReport;
  logic [7:0]  txDataNext;
  logic        grantReport;
  logic        frameDone;
  logic        blank3, blank2, blank1;

  function automatic logic [7:0] encodeDigit(input logic [3:0] d, input logic blank);
    if (blank)
      return 8'h20;
    else if (d > 4'd9)
      return BAD_DIGIT_CHAR;
    else
      return {4'h3, d};
  endfunction

`ifdef MINI_CALC_LEADING_ZERO_BLANK_EN
  // A digit blanks only while every more significant digit was also zero.
  assign blank3 = (snapshot[15:12] == 4'd0);
  assign blank2 = (frame[15:12] == 4'd0) && (frame[11:8] == 4'd0);
  assign blank1 = blank2 && (frame[7:4] == 4'd0);
`else
  assign blank3 = 1'b0;
  assign blank2 = 1'b0;
  assign blank1 = 1'b0;
`endif

  assign TxValid = (state != IDLE);
  assign Busy    = (state != IDLE);
  assign EchoAck = (state == SEND_ECHO) && TxAck;

  always_comb begin
    stateNext   = state;
    txDataNext  = TxData;
    grantReport = 1'b0;
    frameDone   = 1'b0;
    case (state)
      IDLE: begin
        if (EchoValid && (!pending || lastGrantReport)) begin
          stateNext  = SEND_ECHO;
          txDataNext = EchoData;
        end else if (pending) begin
          grantReport = 1'b1;
          stateNext   = SEND_D3;
          txDataNext  = encodeDigit(snapshot[15:12], blank3);
        end
      end
      SEND_ECHO: if (TxAck) stateNext = IDLE;
      SEND_D3: if (TxAck) begin
        stateNext  = SEND_D2;
        txDataNext = encodeDigit(frame[11:8], blank2);
      end
      SEND_D2: if (TxAck) begin
        stateNext  = SEND_D1;
        txDataNext = encodeDigit(frame[7:4], blank1);
      end
      SEND_D1: if (TxAck) begin
        stateNext  = SEND_D0;
        txDataNext = encodeDigit(frame[3:0], 1'b0);
      end
      SEND_D0: if (TxAck) begin
        if (ADD_CRLF) begin
          stateNext  = SEND_CR;
          txDataNext = 8'h0D;
        end else begin
          stateNext = IDLE;
          frameDone = 1'b1;
        end
      end
      SEND_CR: if (TxAck) begin
        stateNext  = SEND_LF;
        txDataNext = 8'h0A;
      end
      SEND_LF: if (TxAck) begin
        stateNext = IDLE;
        frameDone = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      TxData          <= 8'h00;
      pending         <= 1'b0;
      snapshot        <= 16'h0000;
      frame           <= 16'h0000;
      lastGrantReport <= 1'b0;
      Overrun         <= 1'b0;
    end else begin
      state   <= stateNext;
      TxData  <= txDataNext;
      Overrun <= ReportReq && pending && !grantReport;
      // A new request on the grant edge refills the slot just emptied.
      if (ReportReq && (!pending || grantReport)) begin
        pending  <= 1'b1;
        snapshot <= {Digit3, Digit2, Digit1, Digit0};
      end else if (grantReport) begin
        pending <= 1'b0;
      end
      if (grantReport)
        frame <= snapshot;
      if (EchoAck)
        lastGrantReport <= 1'b0;
      else if (frameDone)
        lastGrantReport <= 1'b1;
    end
  end

endmodule
